// File: rtl/nec_ir_decoder.sv
// NEC IR frame decoder feeding 32-bit direction codes to the snake game core.
// Pulse widths are measured between synchronised edges and classified against NEC unit windows.
module nec_ir_decoder #(
  parameter int CLKS_PER_UNIT  = 28125,
  parameter bit CHECK_ADDR_INV = 1'b1
) (
  input  logic        game_clk,
  input  logic        reset_n,
  input  logic        ir_in,
  output logic [31:0] direction,
  output logic        code_valid,
  output logic        repeat_p,
  output logic        frame_err
);

  localparam int W = $clog2(20*CLKS_PER_UNIT+1);

  localparam logic [W-1:0] BURST_MIN = W'(CLKS_PER_UNIT/2);
  localparam logic [W-1:0] BURST_MAX = W'((3*CLKS_PER_UNIT)/2);
  localparam logic [W-1:0] SP1_MIN   = W'(2*CLKS_PER_UNIT);
  localparam logic [W-1:0] SP1_MAX   = W'(4*CLKS_PER_UNIT);
  localparam logic [W-1:0] LEAD_MIN  = W'(14*CLKS_PER_UNIT);
  localparam logic [W-1:0] LEAD_MAX  = W'(18*CLKS_PER_UNIT);
  localparam logic [W-1:0] LHF_MIN   = W'(6*CLKS_PER_UNIT);
  localparam logic [W-1:0] LHF_MAX   = W'(10*CLKS_PER_UNIT);
  localparam logic [W-1:0] LHR_MIN   = W'(3*CLKS_PER_UNIT);
  localparam logic [W-1:0] LHR_MAX   = W'(5*CLKS_PER_UNIT);
  localparam logic [W-1:0] WIDTH_SAT = W'(20*CLKS_PER_UNIT);

  // IDLE wait | LEAD_LO/LEAD_HI leader | BIT_LO/BIT_HI data | STOP final burst | REP_STOP repeat burst
  typedef enum logic [2:0] {IDLE, LEAD_LO, LEAD_HI, BIT_LO, BIT_HI, STOP, REP_STOP} state_t;

  state_t         state, state_n;
  logic           ir_s1, ir_s2, ir_d;
  logic           fall, rise, any_edge;
  logic [W-1:0]   width;
  logic [4:0]     bit_cnt, bit_cnt_n;
  logic [31:0]    shreg, shreg_n, direction_n;
  logic           have_code, have_code_n;
  logic           code_valid_n, repeat_p_n, frame_err_n;
  logic           cmd_ok, addr_ok;

  function automatic logic in_win(input logic [W-1:0] w, input logic [W-1:0] lo,
                                  input logic [W-1:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  assign fall     = ir_d & ~ir_s2;
  assign rise     = ~ir_d & ir_s2;
  assign any_edge = fall | rise;
  assign cmd_ok   = (shreg[15:8] == ~shreg[7:0]);
  assign addr_ok  = !CHECK_ADDR_INV || (shreg[31:24] == ~shreg[23:16]);

  always_ff @(posedge game_clk) begin
    if (!reset_n) begin
      ir_s1      <= 1'b1;
      ir_s2      <= 1'b1;
      ir_d       <= 1'b1;
      width      <= '0;
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      direction  <= '0;
      have_code  <= 1'b0;
      code_valid <= 1'b0;
      repeat_p   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      ir_s1      <= ir_in;
      ir_s2      <= ir_s1;
      ir_d       <= ir_s2;
      if (any_edge)
        width <= '0;
      else if (width != WIDTH_SAT)
        width <= width + 1'b1;
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shreg      <= shreg_n;
      direction  <= direction_n;
      have_code  <= have_code_n;
      code_valid <= code_valid_n;
      repeat_p   <= repeat_p_n;
      frame_err  <= frame_err_n;
    end
  end

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shreg_n      = shreg;
    direction_n  = direction;
    have_code_n  = have_code;
    code_valid_n = 1'b0;
    repeat_p_n   = 1'b0;
    frame_err_n  = 1'b0;

    unique case (state)
      IDLE: if (fall) state_n = LEAD_LO;
      LEAD_LO: if (rise) begin
        if (in_win(width, LEAD_MIN, LEAD_MAX)) begin
          state_n = LEAD_HI;
        end else begin
          // Short lows are treated as noise and dropped without complaint.
          state_n     = IDLE;
          frame_err_n = (width >= LEAD_MIN);
        end
      end
      LEAD_HI: if (fall) begin
        if (in_win(width, LHF_MIN, LHF_MAX)) begin
          state_n   = BIT_LO;
          bit_cnt_n = '0;
        end else if (in_win(width, LHR_MIN, LHR_MAX)) begin
          state_n = REP_STOP;
        end else begin
          state_n     = IDLE;
          frame_err_n = 1'b1;
        end
      end
      BIT_LO: if (rise) begin
        if (in_win(width, BURST_MIN, BURST_MAX)) begin
          state_n = BIT_HI;
        end else begin
          state_n     = IDLE;
          frame_err_n = 1'b1;
        end
      end
      BIT_HI: if (fall) begin
        if (in_win(width, BURST_MIN, BURST_MAX) || in_win(width, SP1_MIN, SP1_MAX)) begin
          shreg_n   = {shreg[30:0], in_win(width, SP1_MIN, SP1_MAX)};
          bit_cnt_n = bit_cnt + 5'd1;
          state_n   = (bit_cnt == 5'd31) ? STOP : BIT_LO;
        end else begin
          state_n     = IDLE;
          frame_err_n = 1'b1;
        end
      end
      STOP: if (rise) begin
        state_n = IDLE;
        if (in_win(width, BURST_MIN, BURST_MAX) && cmd_ok && addr_ok) begin
          direction_n  = shreg;
          code_valid_n = 1'b1;
          have_code_n  = 1'b1;
        end else begin
          frame_err_n = 1'b1;
        end
      end
      REP_STOP: if (rise) begin
        state_n = IDLE;
        if (in_win(width, BURST_MIN, BURST_MAX) && have_code)
          repeat_p_n = 1'b1;
        else
          frame_err_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // A saturated width means the line stalled; abort once and park in IDLE.
    if (state != IDLE && !any_edge && width == WIDTH_SAT) begin
      state_n      = IDLE;
      code_valid_n = 1'b0;
      repeat_p_n   = 1'b0;
      frame_err_n  = 1'b1;
    end
  end

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Self-checking bench for nec_ir_decoder: directed scenarios plus randomised frames
// checked against a byte-level model of what the game core should see.
module tb_nec_ir_decoder;
  localparam int T = 8;
  localparam logic [31:0] UP = 32'h20DF6A95, DOWN = 32'h20DFEA15;
  localparam logic [31:0] LEFT = 32'h20DF1AE5, RIGHT = 32'h20DF9A65;

  logic        game_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ir_in = 1'b1;
  logic [31:0] direction, direction1;
  logic        code_valid, repeat_p, frame_err;
  logic        code_valid1, repeat_p1, frame_err1;

  int errors = 0, checks = 0;
  int n_cv = 0, n_rp = 0, n_fe = 0, n_cv1 = 0, n_rp1 = 0, n_fe1 = 0, n_multi = 0;
  int s_cv, s_rp, s_fe, s_cv1, s_fe1;
  logic [31:0] exp_dir = '0;
  bit exp_have = 1'b0;
  int exp_cv, exp_rp, exp_fe;

  always #5 game_clk = ~game_clk;

  nec_ir_decoder #(.CLKS_PER_UNIT(T), .CHECK_ADDR_INV(1'b1)) dut (
    .game_clk(game_clk), .reset_n(reset_n), .ir_in(ir_in), .direction(direction),
    .code_valid(code_valid), .repeat_p(repeat_p), .frame_err(frame_err));

  nec_ir_decoder #(.CLKS_PER_UNIT(T), .CHECK_ADDR_INV(1'b0)) dut_noaddr (
    .game_clk(game_clk), .reset_n(reset_n), .ir_in(ir_in), .direction(direction1),
    .code_valid(code_valid1), .repeat_p(repeat_p1), .frame_err(frame_err1));

  always @(negedge game_clk) begin
    if (code_valid)  n_cv  <= n_cv + 1;
    if (repeat_p)    n_rp  <= n_rp + 1;
    if (frame_err)   n_fe  <= n_fe + 1;
    if (code_valid1) n_cv1 <= n_cv1 + 1;
    if (repeat_p1)   n_rp1 <= n_rp1 + 1;
    if (frame_err1)  n_fe1 <= n_fe1 + 1;
    if (int'(code_valid) + int'(repeat_p) + int'(frame_err) > 1) n_multi <= n_multi + 1;
  end

  // Model: a frame is accepted when each checked byte plus its partner sums to 0xFF.
  function automatic bit model_ok(input logic [31:0] c, input bit chk_addr);
    bit cmd_pair  = (int'(c[15:8]) + int'(c[7:0]) == 255);
    bit addr_pair = (int'(c[31:24]) + int'(c[23:16]) == 255);
    return cmd_pair && (addr_pair || !chk_addr);
  endfunction

  task automatic model_frame(input logic [31:0] c);
    exp_rp = 0;
    if (model_ok(c, 1'b1)) begin
      exp_cv = 1; exp_fe = 0; exp_dir = c; exp_have = 1'b1;
    end else begin
      exp_cv = 0; exp_fe = 1;
    end
  endtask

  task automatic model_repeat();
    exp_cv = 0;
    exp_rp = exp_have ? 1 : 0;
    exp_fe = exp_have ? 0 : 1;
  endtask

  task automatic snap();
    s_cv = n_cv; s_rp = n_rp; s_fe = n_fe; s_cv1 = n_cv1; s_fe1 = n_fe1;
  endtask

  task automatic hold(input logic lvl, input int n);
    ir_in = lvl;
    repeat (n) @(negedge game_clk);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    ir_in = 1'b1;
    repeat (3) @(negedge game_clk);
    reset_n = 1'b1;
    repeat (2) @(negedge game_clk);
    exp_dir = '0;
    exp_have = 1'b0;
  endtask

  // Ends at a negedge with the stop burst just completed (line still low).
  task automatic send_frame(input logic [31:0] code, input int lead_lo, input int lead_hi,
                            input int burst, input int sp0, input int sp1,
                            input int rst_bit, input int bad_bit, input int bad_len);
    hold(1'b0, lead_lo);
    hold(1'b1, lead_hi);
    for (int i = 0; i < 32; i++) begin
      logic b;
      b = code[31-i];
      if (i == rst_bit) begin
        ir_in = 1'b0;
        @(negedge game_clk);
        reset_n = 1'b0;
        @(negedge game_clk);
        reset_n = 1'b1;
        checks++;
        if (direction !== 32'h0 || code_valid !== 1'b0 || repeat_p !== 1'b0 || frame_err !== 1'b0) begin
          errors++;
          $display("FAIL reset_mid_frame_outputs: dir=%h cv=%b rp=%b fe=%b, required all zero",
                   direction, code_valid, repeat_p, frame_err);
        end
        hold(1'b0, burst - 2);
      end else begin
        hold(1'b0, burst);
      end
      hold(1'b1, (i == bad_bit) ? bad_len : (b ? sp1 : sp0));
    end
    hold(1'b0, burst);
  endtask

  task automatic frame_nom(input logic [31:0] code);
    send_frame(code, 16*T, 8*T, T, T, 3*T, -1, -1, 0);
    hold(1'b1, 40);
  endtask

  task automatic send_repeat(input int lead_lo, input int lead_hi, input int burst);
    hold(1'b0, lead_lo);
    hold(1'b1, lead_hi);
    hold(1'b0, burst);
    hold(1'b1, 40);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (direction !== 32'h0 || code_valid !== 1'b0 || repeat_p !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: dir=%h cv=%b rp=%b fe=%b, required all zero",
               direction, code_valid, repeat_p, frame_err);
    end
  endtask

  task automatic test_valid_frame();
    snap();
    frame_nom(UP);
    model_frame(UP);
    checks++;
    if (direction !== exp_dir) begin
      errors++; $display("FAIL valid_dir: got %h required %h", direction, exp_dir);
    end
    checks++;
    if (n_cv - s_cv != exp_cv || n_rp - s_rp != exp_rp || n_fe - s_fe != exp_fe) begin
      errors++; $display("FAIL valid_pulses: cv/rp/fe=%0d/%0d/%0d required %0d/%0d/%0d",
                         n_cv - s_cv, n_rp - s_rp, n_fe - s_fe, exp_cv, exp_rp, exp_fe);
    end
  endtask

  task automatic test_repeat();
    frame_nom(LEFT);
    model_frame(LEFT);
    snap();
    send_repeat(16*T, 4*T, T);
    model_repeat();
    checks++;
    if (n_rp - s_rp != 1 || n_cv - s_cv != 0 || n_fe - s_fe != 0) begin
      errors++; $display("FAIL repeat_pulses: cv/rp/fe=%0d/%0d/%0d required 0/1/0",
                         n_cv - s_cv, n_rp - s_rp, n_fe - s_fe);
    end
    checks++;
    if (direction !== LEFT) begin
      errors++; $display("FAIL repeat_dir: got %h required %h", direction, LEFT);
    end
    apply_reset();
    snap();
    send_repeat(16*T, 4*T, T);
    model_repeat();
    checks++;
    if (n_rp - s_rp != exp_rp || n_fe - s_fe != exp_fe) begin
      errors++; $display("FAIL repeat_after_reset: rp/fe=%0d/%0d required %0d/%0d",
                         n_rp - s_rp, n_fe - s_fe, exp_rp, exp_fe);
    end
  endtask

  task automatic test_bad_inverse();
    frame_nom(DOWN);
    model_frame(DOWN);
    snap();
    frame_nom(32'h20DF6A94);
    model_frame(32'h20DF6A94);
    checks++;
    if (n_fe - s_fe != 1 || n_cv - s_cv != 0) begin
      errors++; $display("FAIL cmd_inverse_err: cv/fe=%0d/%0d required 0/1", n_cv - s_cv, n_fe - s_fe);
    end
    checks++;
    if (direction !== exp_dir) begin
      errors++; $display("FAIL cmd_inverse_dir: got %h required %h", direction, exp_dir);
    end
    snap();
    frame_nom(32'h21DF6A95);
    model_frame(32'h21DF6A95);
    checks++;
    if (n_fe - s_fe != 1 || n_cv - s_cv != 0 || direction !== exp_dir) begin
      errors++; $display("FAIL addr_inverse_checked: cv/fe=%0d/%0d dir=%h required 0/1 dir=%h",
                         n_cv - s_cv, n_fe - s_fe, direction, exp_dir);
    end
    checks++;
    if (n_cv1 - s_cv1 != 1 || n_fe1 - s_fe1 != 0 || direction1 !== 32'h21DF6A95) begin
      errors++; $display("FAIL addr_inverse_unchecked: cv/fe=%0d/%0d dir=%h required 1/0 dir=21df6a95",
                         n_cv1 - s_cv1, n_fe1 - s_fe1, direction1);
    end
  endtask

  task automatic test_glitch();
    snap();
    hold(1'b0, 10*T);
    hold(1'b1, 40);
    checks++;
    if (n_cv != s_cv || n_rp != s_rp || n_fe != s_fe) begin
      errors++; $display("FAIL glitch_silent: cv/rp/fe=%0d/%0d/%0d required 0/0/0",
                         n_cv - s_cv, n_rp - s_rp, n_fe - s_fe);
    end
    snap();
    frame_nom(LEFT);
    model_frame(LEFT);
    checks++;
    if (n_cv - s_cv != 1 || direction !== exp_dir) begin
      errors++; $display("FAIL glitch_next_frame: cv=%0d dir=%h required 1 dir=%h",
                         n_cv - s_cv, direction, exp_dir);
    end
  endtask

  task automatic test_timeout();
    snap();
    hold(1'b0, 16*T);
    hold(1'b1, 8*T);
    hold(1'b0, 25*T);
    hold(1'b1, 40);
    checks++;
    if (n_fe - s_fe != 1 || n_cv != s_cv || n_rp != s_rp) begin
      errors++; $display("FAIL timeout_err: cv/rp/fe=%0d/%0d/%0d required 0/0/1",
                         n_cv - s_cv, n_rp - s_rp, n_fe - s_fe);
    end
    snap();
    frame_nom(UP);
    model_frame(UP);
    checks++;
    if (n_cv - s_cv != 1 || n_fe != s_fe || direction !== exp_dir) begin
      errors++; $display("FAIL timeout_recover: cv/fe=%0d/%0d dir=%h required 1/0 dir=%h",
                         n_cv - s_cv, n_fe - s_fe, direction, exp_dir);
    end
  endtask

  task automatic test_bad_space();
    snap();
    // 14 clocks lies strictly between the 0-space and 1-space windows.
    send_frame(RIGHT, 16*T, 8*T, T, T, 3*T, -1, 5, 14);
    hold(1'b1, 40);
    checks++;
    if (n_fe - s_fe != 1 || n_cv != s_cv || direction !== exp_dir) begin
      errors++; $display("FAIL bad_space: cv/fe=%0d/%0d dir=%h required 0/1 dir=%h",
                         n_cv - s_cv, n_fe - s_fe, direction, exp_dir);
    end
  endtask

  task automatic test_reset_mid_frame();
    snap();
    send_frame(DOWN, 16*T, 8*T, T, T, 3*T, 15, -1, 0);
    hold(1'b1, 40);
    exp_dir = '0;
    exp_have = 1'b0;
    checks++;
    if (n_cv != s_cv || n_rp != s_rp || n_fe != s_fe || direction !== exp_dir) begin
      errors++; $display("FAIL reset_rest_silent: cv/rp/fe=%0d/%0d/%0d dir=%h required 0/0/0 dir=0",
                         n_cv - s_cv, n_rp - s_rp, n_fe - s_fe, direction);
    end
    snap();
    frame_nom(DOWN);
    model_frame(DOWN);
    checks++;
    if (n_cv - s_cv != 1 || direction !== exp_dir) begin
      errors++; $display("FAIL reset_next_frame: cv=%0d dir=%h required 1 dir=%h",
                         n_cv - s_cv, direction, exp_dir);
    end
  endtask

  task automatic test_scaled_latency();
    for (int s = 0; s < 2; s++) begin
      int b, one;
      // Bit-phase widths scale; the leader windows are too narrow for +-25%, so it stays nominal.
      b   = (s == 0) ? 6 : 10;
      one = (s == 0) ? 18 : 30;
      snap();
      send_frame(RIGHT, 16*T, 8*T, b, b, one, -1, -1, 0);
      model_frame(RIGHT);
      ir_in = 1'b1;
      @(posedge game_clk);
      @(posedge game_clk);
      #1;
      checks++;
      if (code_valid !== 1'b0) begin
        errors++; $display("FAIL latency_early_%0d: cv=%b after 2 edges required 0", s, code_valid);
      end
      @(posedge game_clk);
      #1;
      checks++;
      if (code_valid !== 1'b1) begin
        errors++; $display("FAIL latency_edge3_%0d: cv=%b after 3 edges required 1", s, code_valid);
      end
      @(negedge game_clk);
      hold(1'b1, 40);
      checks++;
      if (n_cv - s_cv != exp_cv || n_fe != s_fe || direction !== exp_dir) begin
        errors++; $display("FAIL scaled_%0d: cv/fe=%0d/%0d dir=%h required %0d/0 dir=%h",
                           s, n_cv - s_cv, n_fe - s_fe, direction, exp_cv, exp_dir);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 16; it++) begin
      int kind, j;
      logic [7:0] a, c;
      logic [31:0] code;
      kind = int'($urandom_range(0, 3));
      j    = int'($urandom_range(0, 2)) - 1;
      a    = 8'($urandom_range(0, 255));
      c    = 8'($urandom_range(0, 255));
      code = (kind == 2) ? $urandom() : {a, ~a, c, ~c};
      snap();
      if (kind == 3) begin
        send_repeat(16*T + j, 4*T + j, T + j);
        model_repeat();
      end else begin
        send_frame(code, 16*T + j, 8*T + j, T + j, T + j, 3*T + j, -1, -1, 0);
        hold(1'b1, 40);
        model_frame(code);
      end
      checks++;
      if (n_cv - s_cv != exp_cv || n_rp - s_rp != exp_rp || n_fe - s_fe != exp_fe ||
          direction !== exp_dir) begin
        errors++;
        $display("FAIL random_%0d kind=%0d code=%h: cv/rp/fe=%0d/%0d/%0d dir=%h required %0d/%0d/%0d dir=%h",
                 it, kind, code, n_cv - s_cv, n_rp - s_rp, n_fe - s_fe, direction,
                 exp_cv, exp_rp, exp_fe, exp_dir);
      end
    end
  endtask

  initial begin
    @(negedge game_clk);
    test_reset();
    test_valid_frame();
    test_repeat();
    test_bad_inverse();
    test_glitch();
    test_timeout();
    test_bad_space();
    test_reset_mid_frame();
    test_scaled_latency();
    test_random();
    checks++;
    if (n_multi != 0) begin
      errors++; $display("FAIL one_pulse_per_cycle: %0d cycles with >1 pulse required 0", n_multi);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
